// File: rtl/wait_state_memory.sv
// ============================================================================
// wait_state_memory : big-endian byte store with programmable wait states
// Revision 1.0
// ============================================================================
`default_nettype none

module wait_state_memory #(
    parameter int MEM_BYTES   = 256,
    parameter int WORD_BYTES  = 2,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset_,
    input  logic [15:0]             addrs_bus,
    input  logic                    request,
    input  logic                    rw,
    output logic                    wait_,
    input  logic [8*WORD_BYTES-1:0] data_bus_write,
    output logic [8*WORD_BYTES-1:0] data_bus_read
);

    localparam int         DW       = 8 * WORD_BYTES;
    localparam int         AW       = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      count;
    logic [AW-1:0]   addr_q;
    logic            rw_q;
    logic [DW-1:0]   wdata_q;
    logic [7:0]      mem [MEM_BYTES] = '{default: 8'h00};

    logic            complete;
    logic [AW-1:0]   acc_base;
    logic            acc_rw;
    logic [DW-1:0]   acc_data;
    logic [AW-1:0]   idx [WORD_BYTES];

    // High address bits are deliberately ignored (address wraps modulo MEM_BYTES).
    logic unused_addr_bits;
    assign unused_addr_bits = ^addrs_bus;

    // With zero wait states the access completes on the acceptance edge itself,
    // so the live bus is used instead of the captured copy.
    always_comb begin
        complete = 1'b0;
        acc_base = addr_q;
        acc_rw   = rw_q;
        acc_data = wdata_q;
        if (state == IDLE) begin
            acc_base = addrs_bus[AW-1:0];
            acc_rw   = rw;
            acc_data = data_bus_write;
            complete = request && (WAIT_CYCLES == 0);
        end else if (state == BUSY) begin
            complete = request && (count == 4'd0);
        end
        for (int k = 0; k < WORD_BYTES; k++) begin
            idx[k] = acc_base + AW'(k);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state         <= IDLE;
            wait_         <= 1'b1;
            data_bus_read <= '0;
            count         <= 4'd0;
            addr_q        <= '0;
            rw_q          <= 1'b1;
            wdata_q       <= '0;
        end else begin
            if (complete) begin
                if (acc_rw) begin
                    for (int k = 0; k < WORD_BYTES; k++) begin
                        data_bus_read[8*(WORD_BYTES-1-k) +: 8] <= mem[idx[k]];
                    end
                end else begin
                    for (int k = 0; k < WORD_BYTES; k++) begin
                        mem[idx[k]] <= acc_data[8*(WORD_BYTES-1-k) +: 8];
                    end
                end
            end
            case (state)
                IDLE: begin
                    if (request) begin
                        addr_q  <= addrs_bus[AW-1:0];
                        rw_q    <= rw;
                        wdata_q <= data_bus_write;
                        count   <= CNT_LOAD;
                        if (WAIT_CYCLES == 0) begin
                            state <= DONE;
                            wait_ <= 1'b0;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!request) begin
                        state <= IDLE;
                    end else if (count == 4'd0) begin
                        state <= DONE;
                        wait_ <= 1'b0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    if (!request) begin
                        state <= IDLE;
                        wait_ <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    wait_ <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
